// File: rtl/audio_pkg.sv
// audio_pkg: shared word width, FSM encoding, sample-pair type and default divider constants
package audio_pkg;
   localparam int AUD_WORD_W      = 16;
   localparam int DEF_BCK_DIV     = 16;
   localparam int DEF_BITS_PER_CH = 16;
   typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;
   typedef struct packed {
      logic [AUD_WORD_W-1:0] l;
      logic [AUD_WORD_W-1:0] r;
   } pair_t;
endpackage

// File: rtl/audio_i2s_frame_scheduler_if.sv
// audio_i2s_frame_scheduler_if: stereo sample-pair valid/ready stream
interface audio_i2s_frame_scheduler_if;
   import audio_pkg::*;
   logic                  s_valid;
   logic                  s_ready;
   logic [AUD_WORD_W-1:0] s_left;
   logic [AUD_WORD_W-1:0] s_right;
   modport master (output s_valid, s_left, s_right, input s_ready);
   modport slave  (input s_valid, s_left, s_right, output s_ready);
endinterface

// File: rtl/audio_bck_divider.sv
// audio_bck_divider: derives AUD_BCK/AUD_LRCK from the system clock plus mid-half and frame-end strobes
module audio_bck_divider
   import audio_pkg::*;
#(
   parameter int BCK_DIV     = DEF_BCK_DIV,
   parameter int BITS_PER_CH = DEF_BITS_PER_CH
) (
   input  logic CLOCK_50,
   input  logic RESET_N,
   input  logic active_i,
   output logic bck_o,
   output logic lrck_o,
   output logic mid_o,
   output logic frame_end_o
);
   localparam int DW = $clog2(BCK_DIV);
   localparam int BW = $clog2(BITS_PER_CH);
   logic [DW-1:0] div_cnt_q, div_cnt_d;
   logic [BW-1:0] bit_cnt_q, bit_cnt_d;
   logic          bck_q, bck_d, lrck_q, lrck_d;
   logic          wrap, bck_fall, half_end;
   // LRCK only ever moves together with a BCK falling edge
   always_comb begin
      wrap        = active_i && div_cnt_q == DW'(BCK_DIV - 1);
      bck_fall    = wrap && bck_q;
      half_end    = bck_fall && bit_cnt_q == BW'(BITS_PER_CH - 1);
      mid_o       = bck_fall && bit_cnt_q == BW'(BITS_PER_CH / 2 - 1);
      frame_end_o = half_end && lrck_q;
      div_cnt_d   = !active_i || wrap ? '0 : div_cnt_q + 1'b1;
      bck_d       = active_i && (bck_q ^ wrap);
      bit_cnt_d   = !active_i || half_end ? '0 : bit_cnt_q + BW'(bck_fall);
      lrck_d      = active_i && (lrck_q ^ half_end);
   end
   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         div_cnt_q <= '0;
         bit_cnt_q <= '0;
         bck_q     <= 1'b0;
         lrck_q    <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         bck_q     <= bck_d;
         lrck_q    <= lrck_d;
      end
   end
   assign bck_o  = bck_q;
   assign lrck_o = lrck_q;
endmodule

// File: rtl/audio_i2s_frame_scheduler.sv
// audio_i2s_frame_scheduler: clocks the I2S serializer and commits sample pairs while each channel is idle
module audio_i2s_frame_scheduler
   import audio_pkg::*;
#(
   parameter int BCK_DIV       = DEF_BCK_DIV,
   parameter int BITS_PER_CH   = DEF_BITS_PER_CH,
   parameter bit UNDERRUN_ZERO = 1'b0
) (
   input  logic                          CLOCK_50,
   input  logic                          RESET_N,
   input  logic                          enable,
   input  logic                          mute,
   audio_i2s_frame_scheduler_if.slave    s,
   output logic                          AUD_BCK,
   output logic                          AUD_LRCK,
   output logic [AUD_WORD_W-1:0]         AUD_inL,
   output logic [AUD_WORD_W-1:0]         AUD_inR,
   output logic                          running,
   output logic                          underrun,
   output logic [15:0]                   underrun_count
);
   state_e                state_q, state_d;
   pair_t                 pend_q, pend_d;
   logic                  pend_vld_q, pend_vld_d, underrun_q, underrun_d;
   logic [AUD_WORD_W-1:0] inl_q, inl_d, inr_q, inr_d, r_next_q, r_next_d;
   logic [15:0]           ucnt_q, ucnt_d;
   logic                  mid, frame_end, accept, lcommit, rcommit;
   audio_bck_divider #(.BCK_DIV(BCK_DIV), .BITS_PER_CH(BITS_PER_CH)) u_div (
      .CLOCK_50    (CLOCK_50),
      .RESET_N     (RESET_N),
      .active_i    (running),
      .bck_o       (AUD_BCK),
      .lrck_o      (AUD_LRCK),
      .mid_o       (mid),
      .frame_end_o (frame_end)
   );
   // Left word is refreshed mid right half, right word mid left half, so neither changes while shifting
   always_comb begin
      accept     = s.s_valid && !pend_vld_q;
      lcommit    = mid && AUD_LRCK;
      rcommit    = mid && !AUD_LRCK;
      state_d    = enable ? RUN : state_q == IDLE || (state_q == STOP && frame_end) ? IDLE : STOP;
      pend_d     = accept ? {s.s_left, s.s_right} : pend_q;
      pend_vld_d = accept || (pend_vld_q && !lcommit);
      underrun_d = lcommit && !pend_vld_q;
      ucnt_d     = ucnt_q + 16'(underrun_d && ucnt_q != 16'hFFFF);
      r_next_d   = !lcommit ? r_next_q : pend_vld_q ? pend_q.r : UNDERRUN_ZERO ? '0 : inr_q;
      inl_d      = !lcommit ? inl_q : mute ? '0 : pend_vld_q ? pend_q.l : UNDERRUN_ZERO ? '0 : inl_q;
      inr_d      = !rcommit ? inr_q : mute ? '0 : r_next_q;
   end
   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         state_q    <= IDLE;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         underrun_q <= 1'b0;
         ucnt_q     <= '0;
         inl_q      <= '0;
         inr_q      <= '0;
         r_next_q   <= '0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         underrun_q <= underrun_d;
         ucnt_q     <= ucnt_d;
         inl_q      <= inl_d;
         inr_q      <= inr_d;
         r_next_q   <= r_next_d;
      end
   end
   assign s.s_ready      = !pend_vld_q;
   assign running        = state_q != IDLE;
   assign underrun       = underrun_q;
   assign underrun_count = ucnt_q;
   assign AUD_inL        = inl_q;
   assign AUD_inR        = inr_q;
endmodule
